// File: rtl/rv32i_lsu_if.sv
// Core-request, response and word-memory port bundle for rv32i_lsu.
// slave = LSU view; master = core plus data-memory view.
interface rv32i_lsu_if #(
   parameter int unsigned ADDR_W = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: word-wide memory port, RMW for SB/SH, load lane extraction.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning.
module rv32i_lsu #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   rv32i_lsu_if.slave  io_bus
);

   typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_t;

   state_t            r_state;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic [15:0]       r_wdata;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic              r_resp_valid;
   logic [31:0]       r_resp_rdata;
   logic              r_resp_err;

   logic        w_illegal;
   logic        w_misalign;
   logic        w_err;
   logic        w_is_sw;
   logic [1:0]  w_off;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [31:0] w_merged;
   logic        w_unused;

   assign w_unused = ^io_bus.req_addr[31:ADDR_W+2];

   assign w_illegal = io_bus.req_we ? !(io_bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                                    : (io_bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misalign = ((io_bus.req_funct3[1:0] == 2'b01) && io_bus.req_addr[0]) ||
                       ((io_bus.req_funct3[1:0] == 2'b10) && (io_bus.req_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif
   assign w_err   = w_illegal | w_misalign;
   assign w_is_sw = io_bus.req_we && (io_bus.req_funct3 == 3'b010);

   // Lane offset with force-alignment for half/word sizes.
   always_comb begin
      w_off = io_bus.req_addr[1:0];
      case (io_bus.req_funct3[1:0])
         2'b01:   w_off = {io_bus.req_addr[1], 1'b0};
         2'b10:   w_off = 2'b00;
         default: w_off = io_bus.req_addr[1:0];
      endcase
   end

   always_comb begin
      w_byte   = io_bus.mem_rdata[{r_off, 3'b000} +: 8];
      w_half   = r_off[1] ? io_bus.mem_rdata[31:16] : io_bus.mem_rdata[15:0];
      w_load   = 32'h0;
      case (r_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'h0, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'h0, w_half};
         3'b010:  w_load = io_bus.mem_rdata;
         default: w_load = 32'h0;
      endcase
      w_merged = io_bus.mem_rdata;
      if (r_funct3[1:0] == 2'b00) begin
         w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end else if (r_off[1]) begin
         w_merged[31:16] = r_wdata;
      end else begin
         w_merged[15:0] = r_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_we         <= 1'b0;
         r_funct3     <= 3'b000;
         r_off        <= 2'b00;
         r_wdata      <= 16'h0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= 32'h0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (io_bus.req_valid) begin
                  r_we     <= io_bus.req_we;
                  r_funct3 <= io_bus.req_funct3;
                  r_off    <= w_off;
                  r_wdata  <= io_bus.req_wdata[15:0];
                  if (w_err) begin
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                     r_resp_rdata <= 32'h0;
                     r_state      <= StResp;
                  end else begin
                     r_mem_en    <= 1'b1;
                     r_mem_we    <= w_is_sw;
                     r_mem_addr  <= io_bus.req_addr[ADDR_W+1:2];
                     r_mem_wdata <= w_is_sw ? io_bus.req_wdata : 32'h0;
                     r_state     <= w_is_sw ? StWr : StRd;
                  end
               end
            end
            StRd: begin
               if (io_bus.mem_ack) begin
                  if (r_we) begin
                     // Sub-word store: read word merged, write phase follows without dropping en.
                     r_mem_we    <= 1'b1;
                     r_mem_wdata <= w_merged;
                     r_state     <= StWr;
                  end else begin
                     r_mem_en     <= 1'b0;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= w_load;
                     r_resp_err   <= 1'b0;
                     r_state      <= StResp;
                  end
               end
            end
            StWr: begin
               if (io_bus.mem_ack) begin
                  r_mem_en     <= 1'b0;
                  r_mem_we     <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= 32'h0;
                  r_resp_err   <= 1'b0;
                  r_state      <= StResp;
               end
            end
            StResp: begin
               r_resp_valid <= 1'b0;
               r_resp_rdata <= 32'h0;
               r_resp_err   <= 1'b0;
               r_state      <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_bus.req_ready  = (r_state == StIdle);
   assign io_bus.resp_valid = r_resp_valid;
   assign io_bus.resp_rdata = r_resp_rdata;
   assign io_bus.resp_err   = r_resp_err;
   assign io_bus.mem_en     = r_mem_en;
   assign io_bus.mem_we     = r_mem_we;
   assign io_bus.mem_addr   = r_mem_addr;
   assign io_bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed table-driven bench for rv32i_lsu with a word-memory model and configurable ack delay.
module tb_rv32i_lsu;
   localparam int unsigned AW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rv32i_lsu_if #(.ADDR_W(AW)) bus ();
   rv32i_lsu #(.ADDR_W(AW)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));

   logic [31:0] mem [32];
   int          ack_delay = 0;
   logic        ack_force = 1'b0;
   int          wait_cnt = 0;
   int          n_reads = 0;
   int          n_writes = 0;
   logic        pre_tog = 1'b0;
   logic        pre_seen = 1'b0;
   int          pre_idx = 0;
   logic [31:0] pre_val = 32'h0;
   int          n_tests = 0;
   int          n_fail = 0;

   // Memory model: acks after ack_delay wait cycles, read data only presented with ack.
   always @(negedge clk) begin
      if (pre_tog != pre_seen) begin
         mem[pre_idx] = pre_val;
         pre_seen = pre_tog;
      end
      bus.mem_ack = ack_force;
      bus.mem_rdata = 32'h0;
      if (bus.mem_en) begin
         if (wait_cnt >= ack_delay) begin
            bus.mem_ack = 1'b1;
            wait_cnt = 0;
            if (bus.mem_we) begin
               mem[bus.mem_addr] = bus.mem_wdata;
               n_writes++;
            end else begin
               bus.mem_rdata = mem[bus.mem_addr];
               n_reads++;
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      @(posedge clk);
      #1;
      pre_idx = idx;
      pre_val = val;
      pre_tog = ~pre_tog;
      @(negedge clk);
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd);
      @(negedge clk);
      check("req_ready", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.req_we     = ~we;
      bus.req_funct3 = 3'b111;
      bus.req_addr   = 32'hFFFF_FFFF;
      bus.req_wdata  = 32'hA5A5_A5A5;
   endtask

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er);
      drive_req(we, f3, addr, wd);
      lat = -1;
      rd  = 32'h0;
      er  = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            lat = c;
            rd  = bus.resp_rdata;
            er  = bus.resp_err;
            break;
         end
      end
      @(negedge clk);
      check("resp_pulse_end", {bus.resp_valid, bus.resp_err, 30'h0} | bus.resp_rdata, 32'h0);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_word;
      int          exp_reads;
      int          exp_writes;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      int          r0;
      int          w0;
      int          widx;
      logic        seen;

      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;

      vecs[0]  = '{1'b0, 3'b010, 32'h0C, 32'h0, 32'h8421F0C3, 32'h8421F0C3, 1'b0, 2, 32'h8421F0C3, 1, 0};
      vecs[1]  = '{1'b0, 3'b000, 32'h0C, 32'h0, 32'h8421F0C3, 32'hFFFFFFC3, 1'b0, 2, 32'h8421F0C3, 1, 0};
      vecs[2]  = '{1'b0, 3'b100, 32'h0D, 32'h0, 32'h8421F0C3, 32'h000000F0, 1'b0, 2, 32'h8421F0C3, 1, 0};
      vecs[3]  = '{1'b0, 3'b001, 32'h0E, 32'h0, 32'h8421F0C3, 32'hFFFF8421, 1'b0, 2, 32'h8421F0C3, 1, 0};
      vecs[4]  = '{1'b0, 3'b101, 32'h0C, 32'h0, 32'h8421F0C3, 32'h0000F0C3, 1'b0, 2, 32'h8421F0C3, 1, 0};
      vecs[5]  = '{1'b0, 3'b000, 32'h0F, 32'h0, 32'h8421F0C3, 32'hFFFFFF84, 1'b0, 2, 32'h8421F0C3, 1, 0};
      vecs[6]  = '{1'b0, 3'b100, 32'h0E, 32'h0, 32'h8421F0C3, 32'h00000021, 1'b0, 2, 32'h8421F0C3, 1, 0};
      vecs[7]  = '{1'b1, 3'b000, 32'h0E, 32'h000000AB, 32'h11223344, 32'h0, 1'b0, 3, 32'h11AB3344, 1, 1};
      vecs[8]  = '{1'b1, 3'b001, 32'h0C, 32'h1234BEEF, 32'h11223344, 32'h0, 1'b0, 3, 32'h1122BEEF, 1, 1};
      vecs[9]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 32'h0, 1'b0, 2, 32'hDEADBEEF, 0, 1};
      vecs[10] = '{1'b0, 3'b011, 32'h0C, 32'h0, 32'h8421F0C3, 32'h0, 1'b1, 1, 32'h8421F0C3, 0, 0};
      vecs[11] = '{1'b1, 3'b100, 32'h0C, 32'h55, 32'h11223344, 32'h0, 1'b1, 1, 32'h11223344, 0, 0};
`ifdef LSU_MISALIGN_TRAP_EN
      vecs[12] = '{1'b1, 3'b010, 32'h0E, 32'hCAFEF00D, 32'h11223344, 32'h0, 1'b1, 1, 32'h11223344, 0, 0};
      vecs[13] = '{1'b0, 3'b001, 32'h0F, 32'h0, 32'h8421F0C3, 32'h0, 1'b1, 1, 32'h8421F0C3, 0, 0};
`else
      vecs[12] = '{1'b1, 3'b010, 32'h0E, 32'hCAFEF00D, 32'h11223344, 32'h0, 1'b0, 2, 32'hCAFEF00D, 0, 1};
      vecs[13] = '{1'b0, 3'b001, 32'h0F, 32'h0, 32'h8421F0C3, 32'hFFFF8421, 1'b0, 2, 32'h8421F0C3, 1, 0};
`endif
      vecs[14] = '{1'b0, 3'b010, 32'h8C, 32'h0, 32'h8421F0C3, 32'h8421F0C3, 1'b0, 2, 32'h8421F0C3, 1, 0};
      vecs[15] = '{1'b1, 3'b000, 32'h0C, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 3, 32'hFFFFFF00, 1, 1};
      vecs[16] = '{1'b0, 3'b101, 32'h0E, 32'h0, 32'h8421F0C3, 32'h00008421, 1'b0, 2, 32'h8421F0C3, 1, 0};
      vecs[17] = '{1'b1, 3'b001, 32'h0E, 32'h0000CAFE, 32'h11223344, 32'h0, 1'b0, 3, 32'hCAFE3344, 1, 1};

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_en", 32'(bus.mem_en), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_resp", {bus.resp_valid, bus.resp_err, 30'h0} | bus.resp_rdata, 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         widx = int'((vecs[i].addr >> 2) & 32'h1F);
         preload(widx, vecs[i].init);
         r0 = n_reads;
         w0 = n_writes;
         run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, er);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_memword", i), mem[widx], vecs[i].exp_word);
         check($sformatf("vec%0d_reads", i), 32'(n_reads - r0), 32'(vecs[i].exp_reads));
         check($sformatf("vec%0d_writes", i), 32'(n_writes - w0), 32'(vecs[i].exp_writes));
      end

      // Wait states: ack after 3 extra cycles, address held stable, response at N+5.
      ack_delay = 3;
      preload(3, 32'h8421F0C3);
      drive_req(1'b0, 3'b010, 32'h0C, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("ws_en_c%0d", c), 32'(bus.mem_en), 32'd1);
         check($sformatf("ws_we_c%0d", c), 32'(bus.mem_we), 32'd0);
         check($sformatf("ws_addr_c%0d", c), 32'(bus.mem_addr), 32'd3);
         check($sformatf("ws_rv_c%0d", c), 32'(bus.resp_valid), 32'd0);
      end
      @(negedge clk);
      check("ws_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("ws_rdata", bus.resp_rdata, 32'h8421F0C3);
      check("ws_en_dropped", 32'(bus.mem_en), 32'd0);
      @(negedge clk);

      // Reset during RD abandons the access; a stray ack in IDLE is ignored.
      drive_req(1'b0, 3'b010, 32'h0C, 32'h0);
      @(negedge clk);
      check("rrd_en", 32'(bus.mem_en), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rrd_mem_en", 32'(bus.mem_en), 32'd0);
      check("rrd_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rrd_mem_wdata", {31'h0, bus.mem_we} | bus.mem_wdata, 32'd0);
      check("rrd_resp", {bus.resp_valid, bus.resp_err, 30'h0} | bus.resp_rdata, 32'd0);
      check("rrd_ready", 32'(bus.req_ready), 32'd1);
      #1;
      ack_force = 1'b1;
      @(negedge clk);
      #1;
      ack_force = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         seen = seen | bus.resp_valid | bus.mem_en | ~bus.req_ready;
      end
      check("rrd_quiet", 32'(seen), 32'd0);

      // Recovery after reset.
      ack_delay = 0;
      run_req(1'b0, 3'b000, 32'h0F, 32'h0, lat, rd, er);
      check("rec_rdata", rd, 32'hFFFFFF84);
      check("rec_latency", 32'(lat), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
